program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Writable instruction store with a load handshake; drop-in replacement for the fixed program ROM of the paper processor.
- Upstream of the processor core: a host streams a program in word by word.
- When the last word lands, the block asserts core_release, which gates the core's clock enable.
- Read side: combinational address -> data, identical timing to the existing memory block.

Parameters:
- AW, 2, address width; DEPTH = 1<<AW words.
- IW, 2, instruction word width.
- SAFE_WORD, 0, value driven on data whenever the store is not in RUN.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; clears FSM, counters and store
- clk_en  in  1  global advance enable; FSM and writes move only when high (reset overrides)
- load_start  in  1  one-cycle request to (re)load a full program
- ld_valid  in  1  host word valid
- ld_data  in  IW  host instruction word
- ld_ready  out  1  block accepts ld_data this cycle
- address  in  AW  processor fetch address (program counter)
- data  out  IW  fetched instruction
- core_release  out  1  program complete; processor may run
- wr_ptr  out  AW+1  words accepted in the current load (0..DEPTH)
- busy  out  1  high in LOAD

Behaviour:
- Only one clock, clk; reset is synchronous and active-high, sampled on the rising edge of clk. Already decided.
- Reset: state IDLE, wr_ptr=0, all store words=0, ld_ready=0, core_release=0, busy=0, data=SAFE_WORD. This holds even with clk_en low.
- States and transitions:
  - IDLE -> LOAD on load_start && clk_en.
  - LOAD: ld_ready = clk_en. On ld_valid && ld_ready, write store[wr_ptr]=ld_data and increment wr_ptr.
  - LOAD -> RUN on the accept that brings wr_ptr to DEPTH. core_release goes high the next cycle, registered. wr_ptr holds at DEPTH.
  - RUN: data = store[address], purely combinational, no added latency. ld_ready=0.
  - RUN -> LOAD on load_start && clk_en. core_release drops the following cycle, wr_ptr clears to 0 and the old contents are retained until overwritten.
  - LOAD + load_start: restart at wr_ptr=0. Any word presented in that same cycle is discarded (ld_ready forced 0 that cycle).
- IDLE: ld_valid ignored; ld_ready=0.
- Outside RUN: data=SAFE_WORD regardless of address.
- clk_en low: state, wr_ptr and store frozen; ld_ready=0. Combinational read in RUN still valid.
- No wrap-around: wr_ptr never exceeds DEPTH; extra ld_valid in RUN is ignored.
- Reset mid-load: partial program discarded (store zeroed), back to IDLE.

Optional Feature:
- Macro: LOADER_PARITY_EN.
- Defined:
  - Extra input ld_parity (1 bit, even parity over ld_data) and output parity_err (1 bit).
  - An accepted word with a mismatch is not written and wr_ptr does not advance.
  - parity_err is set (sticky) and the FSM enters ERR: ld_ready=0, core_release=0, data=SAFE_WORD.
  - ERR exits only via load_start (to LOAD, parity_err cleared) or reset.
- Undefined: no ld_parity or parity_err ports, no ERR state; every accepted word is written.

Decomposition:
- Shared package: state encoding (IDLE, LOAD, RUN, ERR), default AW, IW and SAFE_WORD constants.
- One natural sub-module, loader_store: DEPTH x IW register array with synchronous write port, synchronous clear and combinational read port.
- The FSM, pointer and handshake stay in program_loader.

Test Plan:
- Reset then idle: data=0 for address=0..3; ld_valid=1 with ld_ready=0; core_release=0.
- Load 2'b01,2'b10,2'b11,2'b00 back-to-back:
  - wr_ptr steps 1..4.
  - core_release=1 one cycle after the 4th accept.
  - address 0..3 read 01,10,11,00 with zero latency.
- Load with gaps and clk_en toggling:
  - words accepted only when ld_valid && clk_en.
  - no write and no wr_ptr change while clk_en=0.
  - final contents correct.
- Reload mid-load:
  - after 2 words, pulse load_start together with ld_valid.
  - that word is dropped and wr_ptr=0.
  - 4 new words load correctly.
- Reset mid-run and mid-load: next cycle state IDLE, store all 0, core_release=0; pulse reset with clk_en=0 to confirm it still takes effect.
- LOADER_PARITY_EN: 3rd word with bad parity:
  - parity_err=1, wr_ptr stays 2, ld_ready=0.
  - load_start clears the error and a good reload reaches RUN.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared definitions for the writable program store: loader state encoding
// and the default geometry / safe fetch word used when the store is not running.
// No logic lives here.
package program_loader_pkg;

  // ERR is only reachable when the parity option is built in.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_ERR  = 2'd3
  } ld_state_e;

  localparam int DEF_AW        = 2;
  localparam int DEF_IW        = 2;
  localparam int DEF_SAFE_WORD = 0;

endpackage

// File: rtl/loader_store.sv
// DEPTH x IW instruction register array: one synchronous write port,
// synchronous whole-array clear, one combinational read port.
// Latency: write visible the cycle after we; read is zero-latency. No backpressure.
// Ports: clk, clr (sync clear, wins over we), we/waddr/wdata, raddr -> rdata.
module loader_store
  import program_loader_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int IW = DEF_IW
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [IW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [IW-1:0] rdata
);

  localparam int DEPTH = 1 << AW;

  logic [IW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/program_loader.sv
// Writable program store with a host load handshake; releases the core once
// a full program (DEPTH words) has been accepted. Fetch read is combinational.
// Backpressure: ld_ready is high only in LOAD with clk_en high and no restart.
// Ports: clk, reset (sync, active-high), clk_en, load_start, ld_valid/ld_data/
// ld_ready (host stream), address -> data (fetch), core_release, wr_ptr, busy.
// Option LOADER_PARITY_EN adds ld_parity (even parity over ld_data), sticky
// parity_err and the ERR state.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int          AW        = DEF_AW,
  parameter int          IW        = DEF_IW,
  parameter logic [IW-1:0] SAFE_WORD = IW'(DEF_SAFE_WORD)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clk_en,
  input  logic          load_start,
  input  logic          ld_valid,
  input  logic [IW-1:0] ld_data,
  output logic          ld_ready,
  input  logic [AW-1:0] address,
  output logic [IW-1:0] data,
  output logic          core_release,
  output logic [AW:0]   wr_ptr,
  output logic          busy
`ifdef LOADER_PARITY_EN
  ,
  input  logic          ld_parity,
  output logic          parity_err
`endif
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] LAST_PTR = (AW+1)'(DEPTH - 1);

  ld_state_e     state_q;
  logic [AW:0]   wr_ptr_q;
  logic          core_release_q;
  logic          accept;
  logic          par_bad;
  logic          store_we;
  logic [IW-1:0] rd_word;

`ifdef LOADER_PARITY_EN
  logic parity_err_q;
  assign par_bad    = ld_parity != (^ld_data);
  assign parity_err = parity_err_q;
`else
  assign par_bad = 1'b0;
`endif

  // A restart request in the same cycle drops the presented word.
  assign ld_ready = (state_q == ST_LOAD) && clk_en && !load_start;
  assign accept   = ld_valid && ld_ready;
  assign store_we = accept && !par_bad;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      wr_ptr_q       <= '0;
      core_release_q <= 1'b0;
`ifdef LOADER_PARITY_EN
      parity_err_q   <= 1'b0;
`endif
    end else if (clk_en) begin
      case (state_q)
        ST_IDLE: begin
          if (load_start) begin
            state_q  <= ST_LOAD;
            wr_ptr_q <= '0;
          end
        end
        ST_LOAD: begin
          if (load_start) begin
            wr_ptr_q <= '0;
          end else if (accept) begin
            if (par_bad) begin
              state_q <= ST_ERR;
`ifdef LOADER_PARITY_EN
              parity_err_q <= 1'b1;
`endif
            end else begin
              wr_ptr_q <= wr_ptr_q + 1'b1;
              if (wr_ptr_q == LAST_PTR) begin
                state_q        <= ST_RUN;
                core_release_q <= 1'b1;
              end
            end
          end
        end
        ST_RUN: begin
          if (load_start) begin
            state_q        <= ST_LOAD;
            wr_ptr_q       <= '0;
            core_release_q <= 1'b0;
          end
        end
        default: begin
`ifdef LOADER_PARITY_EN
          if (load_start) begin
            state_q      <= ST_LOAD;
            wr_ptr_q     <= '0;
            parity_err_q <= 1'b0;
          end
`else
          state_q <= ST_IDLE;
`endif
        end
      endcase
    end
  end

  loader_store #(
    .AW(AW),
    .IW(IW)
  ) u_store (
    .clk  (clk),
    .clr  (reset),
    .we   (store_we),
    .waddr(wr_ptr_q[AW-1:0]),
    .wdata(ld_data),
    .raddr(address),
    .rdata(rd_word)
  );

  assign data         = (state_q == ST_RUN) ? rd_word : SAFE_WORD;
  assign core_release = core_release_q;
  assign wr_ptr       = wr_ptr_q;
  assign busy         = (state_q == ST_LOAD);

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: expected words are queued as the
// host stream is driven and popped when the program is read back in RUN.
// Handshake, pointer and release timing are checked against a small model.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       clk_en;
  logic       load_start;
  logic       ld_valid;
  logic [1:0] ld_data;
  logic       ld_ready;
  logic [1:0] address;
  logic [1:0] data;
  logic       core_release;
  logic [2:0] wr_ptr;
  logic       busy;
`ifdef LOADER_PARITY_EN
  logic       ld_parity;
  logic       parity_err;
`endif

  int checks   = 0;
  int failures = 0;
  logic [1:0] exp_q [$];
  int  exp_ptr;
  bit  bad_par;

  always #5 clk = ~clk;

  program_loader dut (
    .clk         (clk),
    .reset       (reset),
    .clk_en      (clk_en),
    .load_start  (load_start),
    .ld_valid    (ld_valid),
    .ld_data     (ld_data),
    .ld_ready    (ld_ready),
    .address     (address),
    .data        (data),
    .core_release(core_release),
    .wr_ptr      (wr_ptr),
    .busy        (busy)
`ifdef LOADER_PARITY_EN
    ,
    .ld_parity   (ld_parity),
    .parity_err  (parity_err)
`endif
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_word(input logic [1:0] w);
    ld_data = w;
`ifdef LOADER_PARITY_EN
    ld_parity = (^w) ^ bad_par;
`endif
  endtask

  // Present one word in LOAD; accept is expected exactly when valid && en.
  task automatic push(input logic [1:0] w, input bit vld, input bit en, input string nm);
    ld_valid = vld;
    clk_en   = en;
    drive_word(w);
    #1;
    checks++;
    if (ld_ready !== en) begin
      failures++;
      $display("FAIL %s ld_ready got=%b exp=%b", nm, ld_ready, en);
    end
    if (vld && en) begin
      exp_q.push_back(w);
      exp_ptr++;
    end
    cyc();
    ld_valid = 1'b0;
    clk_en   = 1'b1;
    checks++;
    if (wr_ptr !== 3'(exp_ptr)) begin
      failures++;
      $display("FAIL %s wr_ptr got=%0d exp=%0d", nm, wr_ptr, exp_ptr);
    end
  endtask

  task automatic start_load(input string nm);
    clk_en     = 1'b1;
    load_start = 1'b1;
    cyc();
    load_start = 1'b0;
    exp_ptr    = 0;
    exp_q.delete();
    checks++;
    if (busy !== 1'b1 || wr_ptr !== 3'd0 || core_release !== 1'b0) begin
      failures++;
      $display("FAIL %s busy/wr_ptr/core_release got=%b/%0d/%b exp=1/0/0",
               nm, busy, wr_ptr, core_release);
    end
  endtask

  task automatic check_run(input string nm);
    logic [1:0] w;
    checks++;
    if (core_release !== 1'b1 || busy !== 1'b0 || wr_ptr !== 3'd4) begin
      failures++;
      $display("FAIL %s run core_release/busy/wr_ptr got=%b/%b/%0d exp=1/0/4",
               nm, core_release, busy, wr_ptr);
    end
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      #1;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL %s scoreboard empty at addr %0d", nm, a);
      end else begin
        w = exp_q.pop_front();
        checks++;
        if (data !== w) begin
          failures++;
          $display("FAIL %s data[%0d] got=%b exp=%b", nm, a, data, w);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; clk_en = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    ld_valid = 1'b1;
    drive_word(2'b11);
    #1;
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      #1;
      checks++;
      if (data !== 2'b00) begin
        failures++;
        $display("FAIL reset_data[%0d] got=%b exp=00", a, data);
      end
    end
    checks++;
    if (ld_ready !== 1'b0 || core_release !== 1'b0 || busy !== 1'b0 || wr_ptr !== 3'd0) begin
      failures++;
      $display("FAIL reset_outs ready/rel/busy/ptr got=%b/%b/%b/%0d exp=0/0/0/0",
               ld_ready, core_release, busy, wr_ptr);
    end
    cyc();
    checks++;
    if (wr_ptr !== 3'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_ignore ptr/busy got=%0d/%b exp=0/0", wr_ptr, busy);
    end
    ld_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    start_load("b2b_start");
    push(2'b01, 1, 1, "b2b_w0");
    push(2'b10, 1, 1, "b2b_w1");
    push(2'b11, 1, 1, "b2b_w2");
    checks++;
    if (core_release !== 1'b0) begin
      failures++;
      $display("FAIL b2b_early_release got=%b exp=0", core_release);
    end
    push(2'b00, 1, 1, "b2b_w3");
    check_run("b2b");
    // Extra words in RUN are ignored.
    ld_valid = 1'b1;
    drive_word(2'b11);
    #1;
    checks++;
    if (ld_ready !== 1'b0) begin
      failures++;
      $display("FAIL run_ready got=%b exp=0", ld_ready);
    end
    cyc();
    ld_valid = 1'b0;
    checks++;
    if (wr_ptr !== 3'd4 || core_release !== 1'b1) begin
      failures++;
      $display("FAIL run_hold ptr/rel got=%0d/%b exp=4/1", wr_ptr, core_release);
    end
  endtask

  task automatic test_clk_en_gaps();
    start_load("gap_start");
    push(2'b10, 1, 1, "gap_a");
    push(2'b11, 1, 0, "gap_en0");
    push(2'b01, 0, 1, "gap_vld0");
    push(2'b00, 1, 1, "gap_b");
    push(2'b10, 1, 0, "gap_en0b");
    push(2'b01, 1, 1, "gap_c");
    push(2'b11, 0, 0, "gap_idle");
    push(2'b10, 1, 1, "gap_d");
    check_run("gap");
  endtask

  task automatic test_reload_mid_load();
    start_load("rl_start");
    push(2'b11, 1, 1, "rl_w0");
    push(2'b11, 1, 1, "rl_w1");
    load_start = 1'b1;
    ld_valid   = 1'b1;
    drive_word(2'b01);
    #1;
    checks++;
    if (ld_ready !== 1'b0) begin
      failures++;
      $display("FAIL rl_restart_ready got=%b exp=0", ld_ready);
    end
    cyc();
    load_start = 1'b0;
    ld_valid   = 1'b0;
    exp_q.delete();
    exp_ptr = 0;
    checks++;
    if (wr_ptr !== 3'd0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL rl_restart ptr/busy got=%0d/%b exp=0/1", wr_ptr, busy);
    end
    push(2'b00, 1, 1, "rl_n0");
    push(2'b01, 1, 1, "rl_n1");
    push(2'b10, 1, 1, "rl_n2");
    push(2'b01, 1, 1, "rl_n3");
    check_run("rl");
  endtask

  task automatic test_reset_mid();
    // Reset while running, with clk_en held low.
    clk_en = 1'b0;
    reset  = 1'b1;
    cyc();
    reset  = 1'b0;
    address = 2'd1;
    #1;
    checks++;
    if (core_release !== 1'b0 || busy !== 1'b0 || wr_ptr !== 3'd0 || data !== 2'b00) begin
      failures++;
      $display("FAIL rst_run rel/busy/ptr/data got=%b/%b/%0d/%b exp=0/0/0/00",
               core_release, busy, wr_ptr, data);
    end
    clk_en = 1'b1;
    start_load("rst_load_start");
    push(2'b11, 1, 1, "rst_w0");
    clk_en = 1'b0;
    reset  = 1'b1;
    cyc();
    reset  = 1'b0;
    clk_en = 1'b1;
    checks++;
    if (busy !== 1'b0 || wr_ptr !== 3'd0 || core_release !== 1'b0) begin
      failures++;
      $display("FAIL rst_load busy/ptr/rel got=%b/%0d/%b exp=0/0/0", busy, wr_ptr, core_release);
    end
  endtask

`ifdef LOADER_PARITY_EN
  task automatic test_parity();
    start_load("par_start");
    push(2'b01, 1, 1, "par_w0");
    push(2'b11, 1, 1, "par_w1");
    bad_par  = 1'b1;
    ld_valid = 1'b1;
    drive_word(2'b10);
    cyc();
    bad_par = 1'b0;
    drive_word(2'b10);
    #1;
    checks++;
    if (parity_err !== 1'b1 || wr_ptr !== 3'd2 || ld_ready !== 1'b0 ||
        core_release !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL par_err err/ptr/ready/rel/busy got=%b/%0d/%b/%b/%b exp=1/2/0/0/0",
               parity_err, wr_ptr, ld_ready, core_release, busy);
    end
    ld_valid = 1'b0;
    start_load("par_reload");
    checks++;
    if (parity_err !== 1'b0) begin
      failures++;
      $display("FAIL par_clear got=%b exp=0", parity_err);
    end
    push(2'b10, 1, 1, "par_n0");
    push(2'b00, 1, 1, "par_n1");
    push(2'b11, 1, 1, "par_n2");
    push(2'b01, 1, 1, "par_n3");
    check_run("par");
  endtask
`endif

  initial begin
    reset = 1'b1; clk_en = 1'b0; load_start = 1'b0;
    ld_valid = 1'b0; ld_data = 2'b00; address = 2'b00;
    bad_par = 1'b0; exp_ptr = 0;
`ifdef LOADER_PARITY_EN
    ld_parity = 1'b0;
`endif
    test_reset();
    test_back_to_back();
    test_clk_en_gaps();
    test_reload_mid_load();
    test_reset_mid();
`ifdef LOADER_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
